// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg: shared types and default parameters for the button debouncer.
//   btn_state_e        - debouncer FSM state, fixed 2-bit encoding
//   DEF_CNT_WIDTH      - default stability counter width
//   DEF_STABLE_CYCLES  - default samples needed to accept a level change
//   DEF_REPEAT_CYCLES  - default auto-repeat period (BTN_AUTO_REPEAT_EN only)
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        WAIT_RELEASE = 2'd3
    } btn_state_e;

    localparam int unsigned DEF_CNT_WIDTH     = 20;
    localparam int unsigned DEF_STABLE_CYCLES = 1000000;
    localparam int unsigned DEF_REPEAT_CYCLES = 25000000;

endpackage

// File: rtl/btn_pulse_debouncer_if.sv
// -----------------------------------------------------------------------------
// btn_pulse_debouncer_if: raw button input and conditioned button outputs.
//   btn_in      - raw, asynchronous, bouncy button pin
//   btn_level   - debounced level, 1 = pressed
//   btn_press   - one-cycle pulse per accepted press (plus repeats if enabled)
//   btn_release - one-cycle pulse per accepted release
// master: the board/bench side driving the pin; slave: the debouncer.
// -----------------------------------------------------------------------------
interface btn_pulse_debouncer_if;

    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release
    );

endinterface

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff: two-flop synchroniser for a single asynchronous input.
//   clk   - destination clock
//   reset - asynchronous active-high reset, both flops clear to 0
//   d_i   - asynchronous input
//   q_o   - synchronised output (second flop)
// -----------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; second flop gives it a cycle to resolve.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_pulse_debouncer.sv
// -----------------------------------------------------------------------------
// btn_pulse_debouncer: synchronises and debounces one push-button, producing
// a clean level plus single-cycle press/release pulses.
//   clk   - system clock
//   reset - asynchronous active-high reset
//   btn   - btn_pulse_debouncer_if.slave (btn_in in; btn_level, btn_press,
//           btn_release out, all registered)
// Parameters: CNT_WIDTH, STABLE_CYCLES (2..2^CNT_WIDTH-1), REPEAT_CYCLES.
// Optional macro BTN_AUTO_REPEAT_EN: while held, btn_press re-fires every
// REPEAT_CYCLES cycles; when undefined there is one btn_press per press.
// -----------------------------------------------------------------------------
module btn_pulse_debouncer
    import btn_pkg::*;
#(
    parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    btn_pulse_debouncer_if.slave btn
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    // Reject illegal parameterisations at elaboration.
    if (STABLE_CYCLES < 2 ||
        64'(STABLE_CYCLES) > ((64'd1 << CNT_WIDTH) - 64'd1)) begin : g_bad_stable
        $error("btn_pulse_debouncer: STABLE_CYCLES outside 2..2^CNT_WIDTH-1");
    end
    if (64'(REPEAT_CYCLES) > ((64'd1 << (CNT_WIDTH + 6)) - 64'd1)) begin : g_bad_repeat
        $error("btn_pulse_debouncer: REPEAT_CYCLES exceeds 2^(CNT_WIDTH+6)-1");
    end

    logic btn_sync;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (btn.btn_in),
        .q_o   (btn_sync)
    );

    btn_state_e           state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 level_q;
    logic                 press_q;
    logic                 release_q;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int unsigned RPT_W = CNT_WIDTH + 6;
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    // Only advances in PRESSED and is cleared on leaving it, so it is
    // always 0 on (re-)entry and simply holds 0 in WAIT_RELEASE.
    logic [RPT_W-1:0] rpt_q;
`endif

    // Debounce FSM; the counter tracks consecutive samples of the new level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_q     <= '0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (btn_sync) begin
                        state_q <= WAIT_PRESS;
                        cnt_q   <= CNT_WIDTH'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                WAIT_PRESS: begin
                    if (!btn_sync) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= PRESSED;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                PRESSED: begin
                    if (!btn_sync) begin
                        state_q <= WAIT_RELEASE;
                        cnt_q   <= CNT_WIDTH'(1);
`ifdef BTN_AUTO_REPEAT_EN
                        rpt_q   <= '0;
                    end else if (rpt_q == RPT_LAST) begin
                        press_q <= 1'b1;
                        rpt_q   <= '0;
                    end else begin
                        rpt_q   <= rpt_q + RPT_W'(1);
`endif
                    end
                end
                WAIT_RELEASE: begin
                    if (btn_sync) begin
                        state_q   <= PRESSED;
                        cnt_q     <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q     <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign btn.btn_level   = level_q;
    assign btn.btn_press   = press_q;
    assign btn.btn_release = release_q;

endmodule

// File: tb/tb_btn_pulse_debouncer.sv
// -----------------------------------------------------------------------------
// tb_btn_pulse_debouncer: randomized and directed stimulus for
// btn_pulse_debouncer (STABLE_CYCLES=4, REPEAT_CYCLES=10, CNT_WIDTH=4).
// The reference model treats the debouncer as "the level follows the input
// once the input, seen two edges late, has disagreed with it for STABLE
// consecutive samples", and queues the expected pulses with their cycle.
// Honours BTN_AUTO_REPEAT_EN when defined.
// -----------------------------------------------------------------------------
module tb_btn_pulse_debouncer;

    localparam int unsigned S = 4;
    localparam int unsigned R = 10;

    typedef struct {
        bit is_press;
        int cyc;
    } evt_t;

    logic clk = 1'b0;
    logic reset;

    btn_pulse_debouncer_if bif ();

    btn_pulse_debouncer #(
        .CNT_WIDTH     (4),
        .STABLE_CYCLES (S),
        .REPEAT_CYCLES (R)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   done   = 1'b0;

    // reference model state
    bit   m_raw1, m_raw2, m_sprev, m_level;
    int   m_run, m_rpt;
    evt_t exp_q[$];

    task automatic model_reset();
        m_raw1  = 1'b0;
        m_raw2  = 1'b0;
        m_sprev = 1'b0;
        m_level = 1'b0;
        m_run   = 0;
        m_rpt   = 0;
        exp_q.delete();
    endtask

    // Called once per rising edge, after the edge.
    task automatic model_step();
        bit s;
        if (reset) begin
            model_reset();
            return;
        end
        // input sampled at edge e is acted on at edge e+2
        s      = m_raw2;
        m_raw2 = m_raw1;
        m_raw1 = bif.btn_in;
        m_run  = (s != m_level) ? m_run + 1 : 0;
        if (m_run == int'(S)) begin
            m_level = ~m_level;
            m_run   = 0;
            m_rpt   = 0;
            exp_q.push_back('{is_press: m_level, cyc: cyc});
        end else if (m_level && s && m_sprev) begin
            m_rpt++;
            if (m_rpt == int'(R)) begin
                m_rpt = 0;
`ifdef BTN_AUTO_REPEAT_EN
                exp_q.push_back('{is_press: 1'b1, cyc: cyc});
`endif
            end
        end else begin
            m_rpt = 0;
        end
        m_sprev = s;
    endtask

    // Present b to the next rising edge, then advance the model past it.
    task automatic tick(input bit b);
        bif.btn_in = b;
        @(posedge clk);
        cyc++;
        model_step();
        #1;
    endtask

    task automatic hold(input bit b, input int n);
        for (int i = 0; i < n; i++) tick(b);
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        evt_t e;
        forever begin
            @(negedge clk or posedge reset or posedge done);
            if (done) break;
            if (reset) begin
                #1;
                checks++;
                if ({bif.btn_level, bif.btn_press, bif.btn_release} !== 3'b000) begin
                    errors++;
                    $display("FAIL reset_state: got level/press/release=%b%b%b expected 000",
                             bif.btn_level, bif.btn_press, bif.btn_release);
                end
            end else begin
                checks++;
                if (bif.btn_level !== m_level) begin
                    errors++;
                    $display("FAIL level cyc=%0d: got %b expected %b", cyc, bif.btn_level, m_level);
                end
                checks++;
                if (bif.btn_press && bif.btn_release) begin
                    errors++;
                    $display("FAIL both_pulses cyc=%0d: got press=1 release=1 expected not both", cyc);
                end
                if (bif.btn_press || bif.btn_release) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pulse cyc=%0d: got press=%b release=%b expected none",
                                 cyc, bif.btn_press, bif.btn_release);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_press != bif.btn_press || e.cyc != cyc) begin
                            errors++;
                            $display("FAIL pulse: got press=%b at cyc %0d expected press=%b at cyc %0d",
                                     bif.btn_press, cyc, e.is_press, e.cyc);
                        end
                    end
                end
                while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
                    e = exp_q.pop_front();
                    checks++;
                    errors++;
                    $display("FAIL missed_pulse: got nothing expected press=%b at cyc %0d",
                             e.is_press, e.cyc);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_pulses: got %0d outstanding expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Stimulus
    initial begin : stimulus
        int len;
        bit v;
        reset      = 1'b1;
        bif.btn_in = 1'b0;
        model_reset();
        hold(1'b0, 3);
        #2 reset = 1'b0;

        // clean press then release
        hold(1'b0, 3);
        hold(1'b1, 20);
        hold(1'b0, 12);

        // bounce on press
        tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0);
        hold(1'b0, 10);

        // release glitch while pressed
        hold(1'b1, 10);
        hold(1'b0, 2);
        hold(1'b1, 10);
        hold(1'b0, 10);

        // async reset in WAIT_PRESS with cnt=2, then a fresh press
        hold(1'b1, 4);
        #1 reset = 1'b1;
        model_reset();
        hold(1'b1, 2);
        #2 reset = 1'b0;
        hold(1'b1, 12);
        hold(1'b0, 12);

        // async reset during the press pulse
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            if (m_level) break;
        end
        #1 reset = 1'b1;
        model_reset();
        hold(1'b0, 2);
        #2 reset = 1'b0;
        hold(1'b0, 6);

        // long hold for auto-repeat
        hold(1'b1, 50);
        hold(1'b0, 10);

        // back-to-back presses
        hold(1'b1, 8);
        hold(1'b0, 6);
        hold(1'b1, 8);
        hold(1'b0, 10);

        // random segments
        for (int i = 0; i < 60; i++) begin
            v   = 1'($urandom_range(0, 1));
            len = (i % 8 == 7) ? int'($urandom_range(10, 30)) : int'($urandom_range(1, 7));
            hold(v, len);
        end
        hold(1'b0, 12);
        done = 1'b1;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
